// File: rtl/serial_adder.sv
// serial_adder: bit-serial a + b + carry_in through one full-adder cell.
// One operand bit pair per clock, LSB first, valid/ready on both sides.
module serial_adder #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] s_q;
  logic             c_q;
  logic [CW-1:0]    cnt_q;

  logic fa_s;
  logic fa_c;
  logic accept;
  logic last;

  assign fa_s = a_q[0] ^ b_q[0] ^ c_q;
  assign fa_c = (a_q[0] & b_q[0])
              | (a_q[0] & c_q)
              | (b_q[0] & c_q);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign last      = (cnt_q == LAST);

  assign sum       = s_q;
  assign carry_out = c_q;

  // State register; reset wins over any handshake on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode: accept in IDLE, step WIDTH bits, hold result.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = BUSY;
      end
      BUSY: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand, sum and carry shift registers plus bit counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      unique case (1'b1)
        (state_q == IDLE): begin
          if (accept) begin
            a_q   <= a;
            b_q   <= b;
            s_q   <= '0;
            c_q   <= carry_in;
            cnt_q <= '0;
          end
        end
        (state_q == BUSY): begin
          a_q   <= {1'b0, a_q[WIDTH-1:1]};
          b_q   <= {1'b0, b_q[WIDTH-1:1]};
          s_q   <= {fa_s, s_q[WIDTH-1:1]};
          c_q   <= fa_c;
          cnt_q <= cnt_q + ONE;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder.
// A monitor scoreboards every result against queued expectations.
module tb_serial_adder;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_results = 0;
  int n_expect = 0;
  bit rnd_on = 1'b0;

  typedef struct {
    logic [W:0] exp;
    int         t;
  } item_t;

  item_t q[$];

  logic         ov_d = 1'b0;
  logic [W-1:0] sum_d = '0;
  logic         co_d = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [W:0] act,
                     input logic [W:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: push on accept, pop and compare on result handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      ov_d = 1'b0;
    end else begin
      if (out_valid) begin
        chk("in_ready_in_done", {W'(0), in_ready}, '0);
        if (!ov_d) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result actual=%h", {carry_out, sum});
          end else begin
            chk("latency", (W+1)'(cyc - q[0].t), (W+1)'(W));
          end
        end else begin
          chk("hold_sum", {1'b0, sum}, {1'b0, sum_d});
          chk("hold_carry", {W'(0), carry_out}, {W'(0), co_d});
        end
        if (out_ready && q.size() != 0) begin
          item_t it;
          it = q.pop_front();
          chk("result", {carry_out, sum}, it.exp);
          n_results++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{exp: {1'b0, a} + {1'b0, b} + (W+1)'(carry_in),
                      t: cyc + 1});
      end
      ov_d = out_valid;
    end
    sum_d = sum;
    co_d  = carry_out;
  end

  // Random backpressure during the random phase.
  always @(posedge clk) begin
    if (rnd_on) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x,
                      input logic [W-1:0] y,
                      input logic c);
    int n = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    carry_in = c;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=busy required=ready");
    end
    tick();
    in_valid = 1'b0;
    n_expect++;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!out_valid && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic run(input string nm,
                     input logic [W-1:0] x,
                     input logic [W-1:0] y,
                     input logic c,
                     input logic [W:0] exp);
    int k;
    out_ready = 1'b1;
    send(x, y, c);
    wait_valid(k);
    chk({nm, "_lat"}, (W+1)'(k), (W+1)'(W));
    chk(nm, {carry_out, sum}, exp);
    tick();
  endtask

  initial begin
    int k;
    logic [W-1:0] s_hold;

    // Reset held for two edges with in_valid high.
    rst_n = 1'b0;
    in_valid = 1'b1;
    a = 14'h0011;
    b = 14'h0022;
    tick();
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    tick();
    chk("rst_in_ready", {W'(0), in_ready}, (W+1)'(1));
    chk("rst_out_valid", {W'(0), out_valid}, '0);
    chk("rst_sum", {carry_out, sum}, '0);

    // Basic add and ready one cycle after the result handshake.
    run("basic", 14'h0003, 14'h0005, 1'b0, 15'h0008);
    chk("basic_in_ready", {W'(0), in_ready}, (W+1)'(1));
    chk("basic_out_valid", {W'(0), out_valid}, '0);

    // Carry edge cases.
    run("carry_wrap", 14'h3FFF, 14'h0001, 1'b0, 15'h4000);
    run("all_ones", 14'h3FFF, 14'h3FFF, 1'b1, 15'h7FFF);

    // Backpressure with pending new operands.
    out_ready = 1'b0;
    send(14'h0100, 14'h0023, 1'b1);
    wait_valid(k);
    chk("bp_lat", (W+1)'(k), (W+1)'(W));
    chk("bp_result", {carry_out, sum}, 15'h0124);
    s_hold = sum;
    in_valid = 1'b1;
    a = 14'h2000;
    b = 14'h2000;
    carry_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", {W'(0), in_ready}, '0);
      chk("bp_out_valid", {W'(0), out_valid}, (W+1)'(1));
      chk("bp_sum", {1'b0, sum}, {1'b0, s_hold});
    end
    out_ready = 1'b1;
    tick();
    chk("bp_idle_ready", {W'(0), in_ready}, (W+1)'(1));
    tick();
    chk("bp_accepted", {W'(0), in_ready}, '0);
    in_valid = 1'b0;
    n_expect++;
    wait_valid(k);
    chk("bp_second", {carry_out, sum}, 15'h4000);
    tick();

    // Reset while the counter holds 6.
    send(14'h1555, 14'h0AAA, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_expect--;
    chk("mid_in_ready", {W'(0), in_ready}, (W+1)'(1));
    chk("mid_out_valid", {W'(0), out_valid}, '0);
    chk("mid_sum", {carry_out, sum}, '0);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mid_no_result", {W'(0), out_valid}, '0);
    end
    run("after_rst", 14'h1234, 14'h0ABC, 1'b1, 15'h1CF1);

    // Random operands, gaps and backpressure.
    rnd_on = 1'b1;
    for (int i = 0; i < 500; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
      send(W'($urandom), W'($urandom), 1'($urandom));
    end
    @(posedge clk);
    rnd_on = 1'b0;
    #2 out_ready = 1'b1;
    k = 0;
    while (q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    tick();
    chk("drain", (W+1)'(q.size()), '0);
    chk("count", (W+1)'(n_results), (W+1)'(n_expect));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
